// File: rtl/vcpu32_rf_pkg.sv
// Shared types and default geometry for the VCPU-32 multi-port register file.
package vcpu32_rf_pkg;

    localparam int RF_NUM_REGS = 16;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_RD   = 3;
    localparam int RF_NUM_WR   = 2;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read/write ports, scoreboard set, status outputs.
interface regfile_mp_if
    import vcpu32_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          sb_set_en;
    logic [ADDR_W-1:0]             sb_set_addr;
    logic [NUM_REGS-1:0]           sb_pend;
    logic                          wr_conflict;
    logic                          busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, sb_pend, wr_conflict, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, sb_pend, wr_conflict, busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared by any write, set wins on collision.
// One-cycle update; hold input clears and freezes the bits while the array is being swept.
module rf_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int NUM_WR   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          set_en,
    input  logic [ADDR_W-1:0]             set_addr,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    output logic [NUM_REGS-1:0]           pend
);
    logic [NUM_REGS-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) pend_nxt[wr_addr[p]] = 1'b0;
        end
        // Applied last so a newly issued producer outranks the retiring write.
        if (set_en) pend_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || hold) pend <= '0;
        else             pend <= pend_nxt;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads, 1-cycle writes, highest write port wins,
// post-reset clearing sweep (busy); no backpressure. Optional same-cycle bypass: VCPU32_RF_BYPASS_EN.
module regfile_mp
    import vcpu32_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              busy;
    logic              conflict_c;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy      = 1'b0;
        case (state)
            RF_INIT: begin
                busy    = 1'b1;
                idx_nxt = idx + 1'b1;
                if (idx == ADDR_W'(NUM_REGS - 1)) state_nxt = RF_RUN;
            end
            default: ;
        endcase
    end

    // Later loop iterations overwrite earlier ones: highest-numbered port wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_INIT) begin
                mem[idx] <= '0;
            end else begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p]) mem[bus.wr_addr[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    always_comb begin
        conflict_c = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (bus.wr_en[i] && bus.wr_en[j] && (bus.wr_addr[i] == bus.wr_addr[j]))
                    conflict_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bus.wr_conflict <= 1'b0;
        else     bus.wr_conflict <= (state == RF_RUN) && conflict_c;
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_c[i] = '0;
            if (!busy) begin
                rd_data_c[i] = mem[bus.rd_addr[i]];
`ifdef VCPU32_RF_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p] && (bus.wr_addr[p] == bus.rd_addr[i]))
                        rd_data_c[i] = bus.wr_data[p];
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.busy    = busy;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .hold     (busy),
        .set_en   (bus.sb_set_en),
        .set_addr (bus.sb_set_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .pend     (bus.sb_pend)
    );
endmodule
